// File: rtl/axi_read_responder_if.sv
// rtl/axi_read_responder_if.sv - AXI read address/data channel bundle
interface axi_read_responder_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int ID_WIDTH   = 4
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [ID_WIDTH-1:0]   arid;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [ID_WIDTH-1:0]   rid;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arlen, arid, arvalid, rready,
        input  arready, rdata, rid, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arid, arvalid, rready,
        output arready, rdata, rid, rlast, rvalid
    );
endinterface

// File: rtl/axi_read_responder.sv
// rtl/axi_read_responder.sv - memory-side AXI read slave with in-order request queue
module axi_read_responder #(
    parameter int ADDR_WIDTH  = 26,
    parameter int MEM_AW      = 14,
    parameter int ID_WIDTH    = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int LATENCY     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    axi_read_responder_if.slave bus,
    input  logic              bd_we_i,
    input  logic [MEM_AW-1:0] bd_waddr_i,
    input  logic [31:0]       bd_wdata_i
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [3:0]        LAT     = 4'(LATENCY);
    localparam logic [PW:0]       QD      = (PW+1)'(QUEUE_DEPTH);
    localparam logic [PW:0]       CNT_ONE = 1;
    localparam logic [PW-1:0]     PTR_ONE = 1;
    localparam logic [MEM_AW-1:0] IDX_ONE = 1;

    logic [31:0]         mem   [0:(1<<MEM_AW)-1];
    logic [MEM_AW-1:0]   q_idx [QUEUE_DEPTH];
    logic [7:0]          q_len [QUEUE_DEPTH];
    logic [ID_WIDTH-1:0] q_id  [QUEUE_DEPTH];

    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW:0]         count_q;
    logic [1:0]          state_q, state_d;
    logic [MEM_AW-1:0]   cur_idx_q, cur_idx_d;
    logic [7:0]          beats_left_q, beats_left_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d;
    logic [3:0]          lat_cnt_q, lat_cnt_d;
    logic [31:0]         rdata_q;

    logic                full, empty, push, pop, beat_fire, last_beat, rd_en;
    logic [MEM_AW-1:0]   rd_addr;
    logic                unused_addr_bits;

    assign full      = (count_q == QD);
    assign empty     = (count_q == '0);
    assign push      = bus.arvalid & ~full;
    assign last_beat = (beats_left_q == 8'd0);
    assign beat_fire = bus.rvalid & bus.rready;

    assign bus.arready = ~full;
    assign bus.rvalid  = (state_q == S_BURST);
    assign bus.rlast   = bus.rvalid & last_beat;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;

    // Upper address bits alias onto the array; the byte offset is ignored.
    assign unused_addr_bits = ^{bus.araddr[1:0], bus.araddr[ADDR_WIDTH-1:MEM_AW+2]};

    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        beats_left_d = beats_left_q;
        rid_d        = rid_q;
        lat_cnt_d    = lat_cnt_q;
        pop          = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = cur_idx_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) pop = 1'b1;
            end
            S_WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    state_d = S_BURST;
                    rd_en   = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            S_BURST: begin
                if (beat_fire) begin
                    if (!last_beat) begin
                        cur_idx_d    = cur_idx_q + IDX_ONE;
                        beats_left_d = beats_left_q - 8'd1;
                        rd_en        = 1'b1;
                        rd_addr      = cur_idx_q + IDX_ONE;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            state_d      = S_WAIT;
            cur_idx_d    = q_idx[rd_ptr_q];
            beats_left_d = q_len[rd_ptr_q];
            rid_d        = q_id[rd_ptr_q];
            lat_cnt_d    = LAT;
        end
    end

    // Array storage carries no reset so preloaded images survive rst_n.
    always_ff @(posedge clk) begin
        if (bd_we_i) mem[bd_waddr_i] <= bd_wdata_i;
        if (push) begin
            q_idx[wr_ptr_q] <= bus.araddr[2 +: MEM_AW];
            q_len[wr_ptr_q] <= bus.arlen;
            q_id[wr_ptr_q]  <= bus.arid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            cur_idx_q    <= '0;
            beats_left_q <= '0;
            rid_q        <= '0;
            lat_cnt_q    <= '0;
            rdata_q      <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            beats_left_q <= beats_left_d;
            rid_q        <= rid_d;
            lat_cnt_q    <= lat_cnt_d;
            if (rd_en) rdata_q <= mem[rd_addr];
        end
    end
endmodule

// File: tb/tb_axi_read_responder.sv
// tb/tb_axi_read_responder.sv - directed self-checking bench for axi_read_responder
module tb_axi_read_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        bd_we;
    logic [13:0] bd_waddr;
    logic [31:0] bd_wdata;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    axi_read_responder_if #(.ADDR_WIDTH(26), .ID_WIDTH(4)) bus ();

    axi_read_responder #(
        .ADDR_WIDTH(26), .MEM_AW(14), .ID_WIDTH(4), .QUEUE_DEPTH(4), .LATENCY(3)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .bd_we_i(bd_we), .bd_waddr_i(bd_waddr), .bd_wdata_i(bd_wdata)
    );

    task automatic send_req(input logic [25:0] addr, input logic [7:0] len, input logic [3:0] id);
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arid    = id;
        bus.arvalid = 1'b1;
        for (int i = 0; i < 100 && !bus.arready; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    task automatic wait_rvalid(output int n);
        n = 0;
        while (!bus.rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bd_we = 1'b1; bd_waddr = 14'(i); bd_wdata = 32'h1000 + 32'(i);
        end
        @(negedge clk);
        bd_waddr = 14'd16383; bd_wdata = 32'h4FFF;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", bus.rvalid); end
        n_checks++; if (bus.rlast !== 1'b0) begin n_fail++; $display("FAIL reset_rlast got %b want 0", bus.rlast); end
        n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
        n_checks++; if (bus.rid !== 4'h0) begin n_fail++; $display("FAIL reset_rid got %h want 0", bus.rid); end
        n_checks++; if (bus.arready !== 1'b1) begin n_fail++; $display("FAIL reset_arready got %b want 1", bus.arready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_burst();
        int n;
        bus.rready = 1'b1;
        send_req(26'h40, 8'd3, 4'd5);
        wait_rvalid(n);
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL single_latency got %0d want 5", n); end
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL single_rvalid beat %0d got %b want 1", j, bus.rvalid); end
            n_checks++; if (bus.rdata !== 32'h1010 + 32'(j)) begin n_fail++; $display("FAIL single_rdata beat %0d got %h want %h", j, bus.rdata, 32'h1010 + 32'(j)); end
            n_checks++; if (bus.rlast !== (j == 3)) begin n_fail++; $display("FAIL single_rlast beat %0d got %b want %b", j, bus.rlast, (j == 3)); end
            n_checks++; if (bus.rid !== 4'd5) begin n_fail++; $display("FAIL single_rid beat %0d got %h want 5", j, bus.rid); end
            @(negedge clk);
        end
        n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL single_end got %b want 0", bus.rvalid); end
    endtask

    task automatic test_backpressure();
        int   n;
        int   acc;
        logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bus.rready = 1'b0;
        send_req(26'h40, 8'd3, 4'd6);
        wait_rvalid(n);
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL bp_latency got %0d want 5", n); end
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            n_checks++; if (bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL bp_rvalid cycle %0d got %b want 1", i, bus.rvalid); end
            n_checks++; if (bus.rdata !== 32'h1010 + 32'(acc)) begin n_fail++; $display("FAIL bp_rdata cycle %0d got %h want %h", i, bus.rdata, 32'h1010 + 32'(acc)); end
            n_checks++; if (bus.rlast !== (acc == 3)) begin n_fail++; $display("FAIL bp_rlast cycle %0d got %b want %b", i, bus.rlast, (acc == 3)); end
            bus.rready = pat[i];
            if (pat[i]) acc++;
            @(negedge clk);
        end
        bus.rready = 1'b0;
        n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL bp_extra_beat got %b want 0", bus.rvalid); end
    endtask

    task automatic test_queue_full();
        int n;
        int got;
        bit pend;
        bus.rready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            n_checks++; if (bus.arready !== 1'b1) begin n_fail++; $display("FAIL qf_arready_open push %0d got %b want 1", i, bus.arready); end
            bus.araddr = 26'((32 + i - 1) * 4); bus.arlen = 8'd0; bus.arid = 4'(i); bus.arvalid = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (bus.arready !== 1'b0) begin n_fail++; $display("FAIL qf_arready_full got %b want 0", bus.arready); end
        bus.araddr = 26'(37 * 4); bus.arid = 4'd6;
        n = 0;
        while (!bus.rvalid && n < 50) begin
            n_checks++; if (bus.arready !== 1'b0) begin n_fail++; $display("FAIL qf_arready_stall got %b want 0", bus.arready); end
            @(negedge clk);
            n++;
        end
        bus.rready = 1'b1;
        got = 0;
        pend = 1'b0;
        for (int c = 0; c < 100 && got < 6; c++) begin
            if (pend) begin bus.arvalid = 1'b0; pend = 1'b0; end
            if (bus.arvalid && bus.arready) pend = 1'b1;
            if (bus.rvalid) begin
                n_checks++; if (bus.rid !== 4'(got + 1)) begin n_fail++; $display("FAIL qf_rid beat %0d got %h want %h", got, bus.rid, 4'(got + 1)); end
                n_checks++; if (bus.rdata !== 32'h1020 + 32'(got)) begin n_fail++; $display("FAIL qf_rdata beat %0d got %h want %h", got, bus.rdata, 32'h1020 + 32'(got)); end
                got++;
            end
            @(negedge clk);
        end
        bus.arvalid = 1'b0;
        n_checks++; if (got !== 6) begin n_fail++; $display("FAIL qf_drain_count got %0d want 6", got); end
    endtask

    task automatic test_wrap();
        int n;
        bus.rready = 1'b1;
        send_req(26'hFFFC, 8'd1, 4'd3);
        wait_rvalid(n);
        n_checks++; if (bus.rdata !== 32'h4FFF) begin n_fail++; $display("FAIL wrap_beat0 got %h want 00004fff", bus.rdata); end
        n_checks++; if (bus.rlast !== 1'b0) begin n_fail++; $display("FAIL wrap_rlast0 got %b want 0", bus.rlast); end
        @(negedge clk);
        n_checks++; if (bus.rdata !== 32'h1000) begin n_fail++; $display("FAIL wrap_beat1 got %h want 00001000", bus.rdata); end
        n_checks++; if (bus.rlast !== 1'b1) begin n_fail++; $display("FAIL wrap_rlast1 got %b want 1", bus.rlast); end
        @(negedge clk);
    endtask

    task automatic test_backdoor_collision();
        int n;
        bus.rready = 1'b1;
        send_req(26'h20, 8'd1, 4'd7);
        wait_rvalid(n);
        n_checks++; if (bus.rdata !== 32'h1008) begin n_fail++; $display("FAIL bd_beat0 got %h want 00001008", bus.rdata); end
        bd_we = 1'b1; bd_waddr = 14'd9; bd_wdata = 32'hDEAD;
        @(negedge clk);
        bd_we = 1'b0;
        n_checks++; if (bus.rdata !== 32'h1009) begin n_fail++; $display("FAIL bd_collision_old got %h want 00001009", bus.rdata); end
        @(negedge clk);
        send_req(26'h24, 8'd0, 4'd8);
        wait_rvalid(n);
        n_checks++; if (bus.rdata !== 32'hDEAD) begin n_fail++; $display("FAIL bd_new_value got %h want 0000dead", bus.rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int n;
        int extra;
        bus.rready = 1'b1;
        send_req(26'h40, 8'd3, 4'd9);
        send_req(26'h60, 8'd0, 4'd11);
        wait_rvalid(n);
        @(negedge clk);
        n_checks++; if (bus.rdata !== 32'h1011) begin n_fail++; $display("FAIL rst_mid_beat2 got %h want 00001011", bus.rdata); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rvalid got %b want 0", bus.rvalid); end
        n_checks++; if (bus.arready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_arready got %b want 1", bus.arready); end
        @(negedge clk);
        rst_n = 1'b1;
        send_req(26'h50, 8'd0, 4'd10);
        wait_rvalid(n);
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL rst_after_latency got %0d want 5", n); end
        n_checks++; if (bus.rdata !== 32'h1014) begin n_fail++; $display("FAIL rst_after_rdata got %h want 00001014", bus.rdata); end
        n_checks++; if (bus.rid !== 4'd10) begin n_fail++; $display("FAIL rst_after_rid got %h want a", bus.rid); end
        @(negedge clk);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.rvalid) extra++;
            @(negedge clk);
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL rst_queue_flushed got %0d beats want 0", extra); end
    endtask

    initial begin
        bus.araddr  = '0;
        bus.arlen   = '0;
        bus.arid    = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bd_we       = 1'b0;
        bd_waddr    = '0;
        bd_wdata    = '0;
        test_reset();
        preload();
        test_single_burst();
        test_backpressure();
        test_queue_full();
        test_wrap();
        test_backdoor_collision();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
